// File: rtl/seqdiv_if.sv
// seqdiv_if: load/out_valid handshake bundle for the sequential divider.
//   load, in_dividend, in_divisor       : requester -> divider
//   out_quot, out_rem, out_valid,
//   out_busy, out_div0                  : divider -> requester
// The master modport is the requester side (datapath controller).
// The slave modport is the divider side.
interface seqdiv_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] in_dividend;
  logic [WIDTH-1:0] in_divisor;
  logic [WIDTH-1:0] out_quot;
  logic [WIDTH-1:0] out_rem;
  logic             out_valid;
  logic             out_busy;
  logic             out_div0;

  modport master (
    output load, in_dividend, in_divisor,
    input  out_quot, out_rem, out_valid, out_busy, out_div0
  );

  modport slave (
    input  load, in_dividend, in_divisor,
    output out_quot, out_rem, out_valid, out_busy, out_div0
  );
endinterface

// File: rtl/seqdiv.sv
// seqdiv: sequential restoring divider, unsigned WIDTH-bit dividend/divisor.
// Produces one quotient bit per clock, so a result is ready WIDTH cycles
// after the load is accepted. A zero divisor is flagged after one cycle.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high; clears all state and outputs
//   bus    : seqdiv_if slave
//            (load, in_dividend, in_divisor ->
//             out_quot, out_rem, out_valid, out_busy, out_div0)
// A load is accepted in IDLE or DONE and ignored while busy (CALC).
module seqdiv #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     reset,
  seqdiv_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // The remainder is stored in WIDTH bits because it is always below the
  // divisor after a step. The shifted working value needs WIDTH+1 bits so
  // that the compare against the divisor never overflows.
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] div_r;
  logic [CW-1:0]    cnt_r;

  logic [WIDTH-1:0] quot_o;
  logic [WIDTH-1:0] rem_o;
  logic             valid_o;
  logic             busy_o;
  logic             div0_o;

  logic             accept;
  logic             div_zero;
  logic             last_step;
  logic             ge;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quot_step;

  // One restoring step: shift {R,Q} left, trial-subtract the divisor.
  always_comb begin
    accept    = (state != CALC) && bus.load;
    div_zero  = (bus.in_divisor == '0);
    last_step = (state == CALC) && (cnt_r == CW'(1));
    rem_shift = {rem_r, quot_r[WIDTH-1]};
    ge        = (rem_shift >= {1'b0, div_r});
    rem_step  = ge ? WIDTH'(rem_shift - {1'b0, div_r}) : rem_shift[WIDTH-1:0];
    quot_step = {quot_r[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (bus.load) state_nxt = div_zero ? DONE : CALC;
      end
      CALC: begin
        if (last_step) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_r   <= '0;
      quot_r  <= '0;
      div_r   <= '0;
      cnt_r   <= '0;
      quot_o  <= '0;
      rem_o   <= '0;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      div0_o  <= 1'b0;
    end else if (accept) begin
      if (div_zero) begin
        // Divide by zero bypasses CALC: all-ones quotient, dividend as remainder.
        quot_o  <= '1;
        rem_o   <= bus.in_dividend;
        div0_o  <= 1'b1;
        valid_o <= 1'b1;
        busy_o  <= 1'b0;
      end else begin
        div_r   <= bus.in_divisor;
        quot_r  <= bus.in_dividend;
        rem_r   <= '0;
        cnt_r   <= CW'(WIDTH);
        valid_o <= 1'b0;
        div0_o  <= 1'b0;
        busy_o  <= 1'b1;
      end
    end else if (state == CALC) begin
      rem_r  <= rem_step;
      quot_r <= quot_step;
      cnt_r  <= cnt_r - CW'(1);
      if (last_step) begin
        quot_o  <= quot_step;
        rem_o   <= rem_step;
        valid_o <= 1'b1;
        busy_o  <= 1'b0;
      end
    end
  end

  assign bus.out_quot  = quot_o;
  assign bus.out_rem   = rem_o;
  assign bus.out_valid = valid_o;
  assign bus.out_busy  = busy_o;
  assign bus.out_div0  = div0_o;

endmodule
